ahb_sram_if: RTL
================

Name: ahb_sram_if

Overview:
- AHB-Lite slave front end that drives the two-bank, byte-lane SRAM core: 64 KB total, 2 banks x 4 byte lanes x 8K words.
- Decodes each AHB transfer into per-lane active-low chip selects, a write strobe, a word address and write data.
- Steers the 8 byte read buses back onto hrdata.
- Sits between the AHB interconnect and the SRAM core.
- Inserts one wait state only when a read address phase collides with a write data phase.

Parameters:
- AW, 13, SRAM word-address width (sram_addr).
- BANK_BIT, 15, haddr bit selecting bank1 (1) vs bank0 (0).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- hsel  in  1  slave select.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1 = write.
- hsize  in  3  0 = byte, 1 = half, 2 = word; >2 is illegal.
- haddr  in  16  byte address.
- hwdata  in  32  write data, valid in the data phase.
- hready_in  in  1  bus HREADY.
- hready_out  out  1  slave HREADYOUT.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  32  read data.
- bank0_csn  out  4  bank0 lane selects, active-low.
- bank1_csn  out  4  bank1 lane selects, active-low.
- sram_we  out  1  1 = write cycle.
- sram_wdata  out  32  lane n = bits [8n+7:8n].
- sram_addr  out  AW  haddr[AW+1:2].
- sram_q0..sram_q7  in  8 each  q0-3 = bank0 lanes 0-3, q4-7 = bank1 lanes 0-3; valid the cycle after the select.

Behaviour:
- Accept rule: a transfer is accepted when hsel & htrans[1] & hready_in. IDLE/BUSY or hsel=0 gets OKAY, zero wait, no SRAM access.
- Lane decode:
  - byte: lane = haddr[1:0].
  - half: haddr[1] ? 1100 : 0011.
  - word: 1111.
  - Error cases: half with haddr[0]=1, word with haddr[1:0]!=0, or hsize>2. These give an ERROR response and no SRAM access.
- Reset values: bank*_csn=4'hF, sram_we=0, sram_addr=0, sram_wdata=0, hready_out=1, hresp=0, hrdata=0, state=IDLE, all pending registers cleared.
- FSM states: IDLE, WDATA, RSTALL, RDATA, ERR1, ERR2.
- Write path:
  - Address phase: register bank, lanes and word address; go to WDATA.
  - WDATA: drive csn low on the registered lanes of the registered bank, sram_we=1, sram_wdata=hwdata; hready_out=1 (zero wait).
- Read path, no collision:
  - Address phase: drive csn low combinationally on all 4 lanes of the bank, sram_we=0, sram_addr from haddr; go to RDATA.
  - RDATA: hrdata = {q3,q2,q1,q0} if the registered bank is 0, else {q7,q6,q5,q4}; hready_out=1. Read latency is 1 cycle (zero wait).
- Read-after-write collision: a read accepted during WDATA is registered, and the write uses the SRAM that cycle. Next state is RSTALL.
  - RSTALL: issue the read from the registered address; hready_out=0; hrdata=0.
  - Then RDATA: data out, hready_out=1. Exactly 1 wait state.
- Back-to-back transfers: a new accepted transfer in WDATA, RDATA or ERR2 is decoded normally; pipelining is continuous.
- hrdata is 0 in every cycle that is not an RDATA completion.
- Error response:
  - ERR1: hready_out=0, hresp=1.
  - ERR2: hready_out=1, hresp=1.
  - A transfer accepted in ERR2 is processed normally; a master cancelling to IDLE returns the FSM to IDLE.
- Nothing is accepted in RSTALL or ERR1, because hready_in=0 in those cycles.
- Asynchronous rst mid-transfer: a pending write or read is discarded with no SRAM strobe after reset; outputs go to their reset values immediately.
- Single-port rule: never assert sram_we together with a read select in the same cycle; at most one bank is selected per cycle.

Decomposition:
- Package ahb_sram_pkg:
  - HTRANS codes.
  - HSIZE codes.
  - HRESP codes.
  - FSM state enum.
  - Function lane_mask(hsize, haddr[1:0]) returning a 4-bit mask plus an illegal flag.
- One natural sub-module: ahb_sram_rdmux, registered bank select plus 8-to-4 byte steering and zero-gating of hrdata.

Test Plan:
- Write word 0x1234_5678 @0x0010, then read @0x0010:
  - Write data-phase cycle: bank0_csn=0000, we=1, sram_addr=4.
  - Read data phase: hrdata=0x1234_5678, zero wait.
- Byte write 0xAB @0x8003, then half write 0xCDEF @0x8000, then word read @0x8000:
  - Byte write: bank1_csn=0111.
  - Half write: bank1_csn=1100.
  - Word read: hrdata=0xAB??_CDEF, with ?? being prior contents.
- Write @0x0020 immediately followed by read @0x0020:
  - hready_out=0 for exactly 1 cycle, then hrdata equals the written data.
  - sram_we never overlaps a read select.
- Half access @0x0001 and word access @0x0002:
  - Each gives hresp=1 for 2 cycles, with hready_out 0 then 1.
  - csn stays all-ones throughout.
- hsel=1 with htrans=BUSY, and hsel=0 with htrans=NONSEQ:
  - hready_out=1, hresp=0, no csn activity.
- Assert rst during RSTALL:
  - All csn=F, we=0, hready_out=1, hrdata=0 immediately.
  - No SRAM access after release until a new transfer.

Source files
------------

// File: rtl/ahb_sram_pkg.sv
// Shared AHB codes, FSM state codes and byte-lane decode for the AHB-to-SRAM front end.
package ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WDATA  = 3'd1;
    localparam logic [2:0] ST_RSTALL = 3'd2;
    localparam logic [2:0] ST_RDATA  = 3'd3;
    localparam logic [2:0] ST_ERR1   = 3'd4;
    localparam logic [2:0] ST_ERR2   = 3'd5;

    typedef struct packed {
        logic [3:0] mask;
        logic       illegal;
    } lane_dec_t;

    // Misaligned or oversized transfers come back with an empty mask and illegal set.
    function automatic lane_dec_t lane_mask(input logic [2:0] size, input logic [1:0] a);
        lane_dec_t d;
        d.mask    = 4'b0000;
        d.illegal = 1'b0;
        case (size)
            HSIZE_BYTE: d.mask = 4'b0001 << a;
            HSIZE_HALF: begin
                if (a[0]) d.illegal = 1'b1;
                else      d.mask    = a[1] ? 4'b1100 : 4'b0011;
            end
            HSIZE_WORD: begin
                if (a != 2'b00) d.illegal = 1'b1;
                else            d.mask    = 4'b1111;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ahb_sram_rdmux.sv
// Read return path: remembers which bank a read went to and steers its four byte lanes
// onto hrdata during the read completion cycle, zero otherwise.
module ahb_sram_rdmux
    import ahb_sram_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            bank_in,
    input  logic            rd_en,
    input  logic [7:0][7:0] q,
    output logic [31:0]     hrdata
);

    logic bank_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       bank_q <= 1'b0;
        else if (load) bank_q <= bank_in;
    end

    always_comb begin
        hrdata = '0;
        if (rd_en) hrdata = bank_q ? q[7:4] : q[3:0];
    end

endmodule

// File: rtl/ahb_sram_if.sv
// AHB-Lite slave front end for the two-bank byte-lane SRAM core. Reads and writes are
// zero-wait; a read address phase landing on a write data phase costs one stall cycle.
module ahb_sram_if
    import ahb_sram_pkg::*;
#(
    parameter int AW       = 13,
    parameter int BANK_BIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hsel,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [15:0]   haddr,
    input  logic [31:0]   hwdata,
    input  logic          hready_in,
    output logic          hready_out,
    output logic          hresp,
    output logic [31:0]   hrdata,
    output logic [3:0]    bank0_csn,
    output logic [3:0]    bank1_csn,
    output logic          sram_we,
    output logic [31:0]   sram_wdata,
    output logic [AW-1:0] sram_addr,
    input  logic [7:0]    sram_q0,
    input  logic [7:0]    sram_q1,
    input  logic [7:0]    sram_q2,
    input  logic [7:0]    sram_q3,
    input  logic [7:0]    sram_q4,
    input  logic [7:0]    sram_q5,
    input  logic [7:0]    sram_q6,
    input  logic [7:0]    sram_q7
);

    logic [2:0]      state, state_nxt;
    logic            accept;
    lane_dec_t       dec;
    logic            addr_bank;
    logic [AW-1:0]   addr_word;
    logic            load_wr, stall_rd, issue_rd;

    logic            wr_bank;
    logic [3:0]      wr_lanes;
    logic [AW-1:0]   wr_addr;
    logic            rd_bank;
    logic [AW-1:0]   rd_addr;
    logic [7:0][7:0] q_all;

    // Gating with rst keeps a live address phase from reaching the SRAM while in reset.
    assign accept    = hsel && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) && hready_in && !rst;
    assign dec       = lane_mask(hsize, haddr[1:0]);
    assign addr_bank = haddr[BANK_BIT];
    assign addr_word = haddr[AW+1:2];

    always_comb begin
        state_nxt = state;
        load_wr   = 1'b0;
        stall_rd  = 1'b0;
        issue_rd  = 1'b0;
        case (state)
            ST_RSTALL: state_nxt = ST_RDATA;
            ST_ERR1:   state_nxt = ST_ERR2;
            default: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (dec.illegal) begin
                        state_nxt = ST_ERR1;
                    end else if (hwrite) begin
                        load_wr   = 1'b1;
                        state_nxt = ST_WDATA;
                    end else if (state == ST_WDATA) begin
                        // The write owns the SRAM this cycle; park the read for one cycle.
                        stall_rd  = 1'b1;
                        state_nxt = ST_RSTALL;
                    end else begin
                        issue_rd  = 1'b1;
                        state_nxt = ST_RDATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wr_bank  <= 1'b0;
            wr_lanes <= '0;
            wr_addr  <= '0;
            rd_bank  <= 1'b0;
            rd_addr  <= '0;
        end else begin
            state <= state_nxt;
            if (load_wr) begin
                wr_bank  <= addr_bank;
                wr_lanes <= dec.mask;
                wr_addr  <= addr_word;
            end
            if (stall_rd) begin
                rd_bank <= addr_bank;
                rd_addr <= addr_word;
            end
        end
    end

    always_comb begin
        bank0_csn  = 4'hF;
        bank1_csn  = 4'hF;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (state == ST_WDATA) begin
            if (wr_bank) bank1_csn = ~wr_lanes;
            else         bank0_csn = ~wr_lanes;
            sram_we    = 1'b1;
            sram_addr  = wr_addr;
            sram_wdata = hwdata;
        end else if (state == ST_RSTALL) begin
            if (rd_bank) bank1_csn = 4'h0;
            else         bank0_csn = 4'h0;
            sram_addr = rd_addr;
        end else if (issue_rd) begin
            if (addr_bank) bank1_csn = 4'h0;
            else           bank0_csn = 4'h0;
            sram_addr = addr_word;
        end
    end

    assign hready_out = !(state == ST_RSTALL || state == ST_ERR1);
    assign hresp      = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign q_all      = {sram_q7, sram_q6, sram_q5, sram_q4, sram_q3, sram_q2, sram_q1, sram_q0};

    ahb_sram_rdmux u_rdmux (
        .clk     (clk),
        .rst     (rst),
        .load    (issue_rd || state == ST_RSTALL),
        .bank_in (issue_rd ? addr_bank : rd_bank),
        .rd_en   (state == ST_RDATA),
        .q       (q_all),
        .hrdata  (hrdata)
    );

endmodule
